rom_image_loader: RTL and testbench

//  Parametrised successor of the startup ROM bootstrap. Walks a chain of ROM records in SPI flash through
//  a byte-reader handshake (spiflash-style active/ack/busy). Writes each record into SDRAM through a

---
 rtl/rom_image_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_rom_image_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_image_loader.sv
// rom_image_loader
//   Walks a chain of ROM records held in SPI flash and copies each record's
//   payload into SDRAM before the CPU is released from reset.
//   Record layout: type byte, LEN_BYTES little-endian length bytes, N data
//   bytes, then an optional checksum byte. A type byte with bit7 set ends the
//   chain.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   step                 clock enable for FSM transitions
//   start                level request; accepted in IDLE/DONE/ERROR on a step
//   rd_addr              flash start address (BASE_ADDR)
//   rd_active/rd_ack     keep the flash read open / consume byte, fetch next
//   rd_busy/rd_data      reader fetching / current byte
//   mem_we/mem_ready     SDRAM write request / acceptance
//   mem_addr/ext/hi/data write offset, bank select, low/high ROM, data
//   busy                 load in progress (OPEN..SUM)
//   boot_done/boot_err   sticky completion / abort flags
//   err_code             0 none, 1 checksum, 2 record limit, 3 zero length
//   rom_count            records completed since the last start
//   dbg_state            current FSM state
//
// Handshakes:
//   Flash reader: an rd_ack pulse consumes the current byte and asks for the
//   next one. The reader needs a clock to raise rd_busy after an ack, so a byte
//   is taken only when rd_ack is low, the clock after the ack has passed, and
//   rd_busy is low.
//   SDRAM: mem_we with mem_addr/mem_data is held stable until a cycle where
//   mem_we & mem_ready; that cycle is the transfer, mem_we drops on the next.
module rom_image_loader #(
    parameter logic [23:0] BASE_ADDR = 24'h100000,
    parameter int          LEN_BYTES = 2,
    parameter int          EXT_W     = 6,
    parameter int          MAX_ROMS  = 16,
    parameter bit          CHECKSUM  = 1'b1,
    localparam int         LEN_W     = 8 * LEN_BYTES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             start,
    output logic [23:0]      rd_addr,
    output logic             rd_active,
    output logic             rd_ack,
    input  logic             rd_busy,
    input  logic [7:0]       rd_data,
    output logic             mem_we,
    input  logic             mem_ready,
    output logic [LEN_W-1:0] mem_addr,
    output logic [EXT_W-1:0] mem_ext,
    output logic             mem_hi,
    output logic [7:0]       mem_data,
    output logic             busy,
    output logic             boot_done,
    output logic             boot_err,
    output logic [1:0]       err_code,
    output logic [4:0]       rom_count,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_OPEN, S_TYPE, S_LEN, S_DATA, S_WRITE, S_SUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [4:0] MAX_CNT  = 5'(MAX_ROMS);
    localparam logic [1:0] LAST_IDX = 2'(LEN_BYTES - 1);

    state_t           state, state_next;
    logic             ack_q;
    logic [LEN_W-1:0] len_q, len_new, offset;
    logic [1:0]       len_idx;
    logic [7:0]       sum_q, sum_chk;
    logic [6:0]       type_q;
    logic             byte_ok, last_off;

    logic c_start, c_ack, c_type, c_done, c_err, c_len_byte, c_len_done;
    logic c_data, c_accept, c_count;
    logic [1:0] c_code;

    assign byte_ok  = !rd_ack && !ack_q && !rd_busy;
    assign last_off = (offset == len_q - LEN_W'(1));
    assign sum_chk  = sum_q + rd_data;

    assign rd_addr   = BASE_ADDR;
    assign mem_addr  = offset;
    assign mem_hi    = type_q[6];
    assign mem_ext   = type_q[EXT_W-1:0];
    assign busy      = (state == S_OPEN) || (state == S_TYPE) || (state == S_LEN) ||
                       (state == S_DATA) || (state == S_WRITE) || (state == S_SUM);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        c_start    = 1'b0;
        c_ack      = 1'b0;
        c_type     = 1'b0;
        c_done     = 1'b0;
        c_err      = 1'b0;
        c_code     = 2'd0;
        c_len_byte = 1'b0;
        c_len_done = 1'b0;
        c_data     = 1'b0;
        c_accept   = 1'b0;
        c_count    = 1'b0;
        len_new    = len_q;
        len_new[8*len_idx +: 8] = rd_data;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (step && start) begin
                    c_start    = 1'b1;
                    c_ack      = 1'b1;
                    state_next = S_OPEN;
                end
            end
            S_OPEN: if (step) state_next = S_TYPE;
            S_TYPE: begin
                if (step && byte_ok) begin
                    if (rd_data[7]) begin
                        c_done     = 1'b1;
                        state_next = S_DONE;
                    end else if (rom_count == MAX_CNT) begin
                        c_err      = 1'b1;
                        c_code     = 2'd2;
                        state_next = S_ERROR;
                    end else begin
                        c_type     = 1'b1;
                        c_ack      = 1'b1;
                        state_next = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (step && byte_ok) begin
                    c_len_byte = 1'b1;
                    if (len_idx != LAST_IDX) begin
                        c_ack = 1'b1;
                    end else if (len_new == '0) begin
                        c_err      = 1'b1;
                        c_code     = 2'd3;
                        state_next = S_ERROR;
                    end else begin
                        c_ack      = 1'b1;
                        c_len_done = 1'b1;
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (step && byte_ok) begin
                    c_data     = 1'b1;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // The SDRAM handshake is not gated by step.
                if (mem_we && mem_ready) begin
                    c_accept = 1'b1;
                    c_ack    = 1'b1;
                    if (!last_off) begin
                        state_next = S_DATA;
                    end else if (CHECKSUM) begin
                        state_next = S_SUM;
                    end else begin
                        c_count    = 1'b1;
                        state_next = S_TYPE;
                    end
                end
            end
            S_SUM: begin
                if (step && byte_ok) begin
                    if (sum_chk == 8'h00) begin
                        c_count    = 1'b1;
                        c_ack      = 1'b1;
                        state_next = S_TYPE;
                    end else begin
                        c_err      = 1'b1;
                        c_code     = 2'd1;
                        state_next = S_ERROR;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_active <= 1'b0;
            rd_ack    <= 1'b0;
            ack_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_data  <= 8'h00;
            offset    <= '0;
            len_q     <= '0;
            len_idx   <= 2'd0;
            sum_q     <= 8'h00;
            type_q    <= 7'h00;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
            err_code  <= 2'd0;
            rom_count <= 5'd0;
        end else begin
            rd_ack <= c_ack;
            ack_q  <= rd_ack;
            if (c_start) begin
                rd_active <= 1'b1;
                boot_done <= 1'b0;
                boot_err  <= 1'b0;
                err_code  <= 2'd0;
                rom_count <= 5'd0;
            end
            if (c_type) begin
                type_q  <= rd_data[6:0];
                len_idx <= 2'd0;
            end
            if (c_len_byte) begin
                len_q   <= len_new;
                len_idx <= len_idx + 2'd1;
            end
            if (c_len_done) begin
                offset <= '0;
                sum_q  <= 8'h00;
            end
            if (c_data) begin
                mem_data <= rd_data;
                mem_we   <= 1'b1;
            end
            if (c_accept) begin
                mem_we <= 1'b0;
                sum_q  <= sum_q + mem_data;
                // Offset stays on the last byte so mem_addr shows it afterwards.
                if (!last_off) offset <= offset + LEN_W'(1);
            end
            if (c_count) rom_count <= rom_count + 5'd1;
            if (c_done) begin
                rd_active <= 1'b0;
                boot_done <= 1'b1;
            end
            if (c_err) begin
                rd_active <= 1'b0;
                boot_err  <= 1'b1;
                err_code  <= c_code;
            end
        end
    end

endmodule

// File: tb/tb_rom_image_loader.sv
module tb_rom_image_loader;

    localparam logic [23:0] BASE = 24'h100000;

    logic        clk, reset, step, start;
    logic [23:0] rd_addr;
    logic        rd_active, rd_ack, rd_busy;
    logic [7:0]  rd_data;
    logic        mem_we, mem_ready;
    logic [15:0] mem_addr;
    logic [5:0]  mem_ext;
    logic        mem_hi;
    logic [7:0]  mem_data;
    logic        busy, boot_done, boot_err;
    logic [1:0]  err_code;
    logic [4:0]  rom_count;
    logic [3:0]  dbg_state;

    rom_image_loader #(.BASE_ADDR(BASE), .MAX_ROMS(2)) dut (
        .clk(clk), .reset(reset), .step(step), .start(start),
        .rd_addr(rd_addr), .rd_active(rd_active), .rd_ack(rd_ack),
        .rd_busy(rd_busy), .rd_data(rd_data),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_ext(mem_ext), .mem_hi(mem_hi), .mem_data(mem_data),
        .busy(busy), .boot_done(boot_done), .boot_err(boot_err),
        .err_code(err_code), .rom_count(rom_count), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [30:0] exp_q[$];   // {hi, ext[5:0], addr[15:0], data[7:0]}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic hi, input logic [5:0] ext, input logic [15:0] addr,
                            input logic [7:0] data);
        exp_q.push_back({hi, ext, addr, data});
    endtask

    // ---------------- flash image + reader model ----------------
    logic [7:0] img [0:1023];
    int img_len;
    int ptr;
    bit opened;
    int busy_cnt;

    assign rd_data = img[ptr];

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 8'hFF;
        img_len = 0;
    endtask

    task automatic put(input logic [7:0] b);
        img[img_len] = b;
        img_len++;
    endtask

    // First ack after rd_active rises opens the stream at the first header
    // byte; later acks advance. Reader goes busy a random 0..3 clks after each ack.
    initial begin
        ptr = 0; opened = 0; busy_cnt = 0; rd_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (!rd_active) begin
                opened   <= 1'b0;
                busy_cnt <= 0;
                rd_busy  <= 1'b0;
            end else if (rd_ack) begin
                automatic int r = $urandom_range(0, 3);
                if (!opened) begin
                    opened <= 1'b1;
                    ptr    <= 0;
                end else begin
                    ptr <= ptr + 1;
                end
                busy_cnt <= r;
                rd_busy  <= (r > 0);
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                rd_busy  <= (busy_cnt > 1);
            end
        end
    end

    // ---------------- step / ready driver ----------------
    bit step_rand, stall_mode, hold_ready;
    int stall_left, stall_cycles;

    initial begin
        step = 1'b1;
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            step = step_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold_ready) begin
                mem_ready = 1'b0;
            end else if (stall_mode && mem_we && mem_addr == 16'h1 && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = step_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {1'b0, mem_hi, mem_ext, mem_addr, mem_data}, 32'hFFFFFFFF);
            end else begin
                automatic logic [30:0] e = exp_q.pop_front();
                check("mem_write", {1'b0, mem_hi, mem_ext, mem_addr, mem_data}, {1'b0, e});
            end
        end
        if (!reset && stall_mode && mem_we && !mem_ready) begin
            stall_cycles++;
            check("stall_hold", {7'd0, rd_ack, mem_addr, mem_data}, {7'd0, 1'b0, 16'h0001, 8'h22});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_load(input string name, input logic exp_done, input logic exp_err,
                            input logic [1:0] exp_code, input logic [4:0] exp_cnt);
        bit seen;
        seen = 0;
        start = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy) seen = 1;
        end
        start = 1'b0;
        check({name, "_start"}, 32'(seen), 32'd1);
        if (seen) check({name, "_cleared"}, {23'd0, boot_done, boot_err, err_code, rom_count}, 32'd0);
        seen = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(posedge clk); #1;
            if (!busy) seen = 1;
        end
        check({name, "_finish"}, 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_flags"}, {23'd0, boot_done, boot_err, err_code, rom_count},
              {23'd0, exp_done, exp_err, exp_code, exp_cnt});
        check({name, "_rd_active"}, 32'(rd_active), 32'd0);
        check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic image_rec1(input logic [7:0] chk);
        clear_img();
        put(8'h41); put(8'h03); put(8'h00);
        put(8'h11); put(8'h22); put(8'h33);
        put(chk); put(8'hFF);
    endtask

    task automatic exp_rec1();
        push_exp(1'b1, 6'h01, 16'h0000, 8'h11);
        push_exp(1'b1, 6'h01, 16'h0001, 8'h22);
        push_exp(1'b1, 6'h01, 16'h0002, 8'h33);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        reset = 1'b1; start = 1'b0;
        step_rand = 0; stall_mode = 0; hold_ready = 0; stall_left = 0; stall_cycles = 0;
        clear_img();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {rd_active, rd_ack, mem_we, mem_hi, mem_ext, mem_data, busy, boot_done,
               boot_err, err_code, rom_count, dbg_state},
              32'd0);
        check("reset_rd_addr", {8'd0, rd_addr}, {8'd0, BASE});
        check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Good record: sum 11+22+33 = 66, 66+9A wraps to 00.
        image_rec1(8'h9A);
        exp_rec1();
        run_load("rec1", 1'b1, 1'b0, 2'd0, 5'd1);
        check("rec1_hi_ext", {25'd0, mem_hi, mem_ext}, 32'h41);

        // Bad checksum: data still written, then abort with code 1.
        image_rec1(8'h00);
        exp_rec1();
        run_load("badsum", 1'b0, 1'b1, 2'd1, 5'd0);

        // Write port stalls 5 clks on the second byte.
        image_rec1(8'h9A);
        exp_rec1();
        stall_mode = 1; stall_left = 5; stall_cycles = 0;
        run_load("stall", 1'b1, 1'b0, 2'd0, 5'd1);
        stall_mode = 0;
        check("stall_cycles", 32'(stall_cycles), 32'd5);

        // Record limit (MAX_ROMS=2): third type byte rejected.
        clear_img();
        put(8'h05); put(8'h01); put(8'h00); put(8'hAA); put(8'h56);
        put(8'h06); put(8'h01); put(8'h00); put(8'hBB); put(8'h45);
        put(8'h07); put(8'h01); put(8'h00); put(8'hCC); put(8'h34);
        put(8'hFF);
        push_exp(1'b0, 6'h05, 16'h0000, 8'hAA);
        push_exp(1'b0, 6'h06, 16'h0000, 8'hBB);
        run_load("limit", 1'b0, 1'b1, 2'd2, 5'd2);

        // Zero-length record.
        clear_img();
        put(8'h03); put(8'h00); put(8'h00); put(8'hFF);
        run_load("zerolen", 1'b0, 1'b1, 2'd3, 5'd0);

        // 256-byte record with a two-byte length, random step/ready gaps.
        // Data i^5A sums to 0x7F80, so the checksum byte is 0x80.
        clear_img();
        put(8'h7F); put(8'h00); put(8'h01);
        for (int i = 0; i < 256; i++) begin
            put(8'(i) ^ 8'h5A);
            push_exp(1'b1, 6'h3F, 16'(i), 8'(i) ^ 8'h5A);
        end
        put(8'h80); put(8'hFF);
        step_rand = 1;
        run_load("long", 1'b1, 1'b0, 2'd0, 5'd1);
        step_rand = 0;
        check("long_last_addr", {16'd0, mem_addr}, 32'h00FF);
        check("long_hi_ext", {25'd0, mem_hi, mem_ext}, 32'h7F);

        // Asynchronous reset while a write is pending.
        image_rec1(8'h9A);
        hold_ready = 1;
        start = 1'b1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy) start = 1'b0;
            if (mem_we) seen = 1;
        end
        start = 1'b0;
        check("arst_reached_write", 32'(seen), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_outputs",
              {rd_active, rd_ack, mem_we, busy, boot_done, boot_err, err_code, rom_count, dbg_state},
              32'd0);
        check("arst_rd_addr", {8'd0, rd_addr}, {8'd0, BASE});
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        hold_ready = 0;
        @(posedge clk);
        #1;
        exp_rec1();
        run_load("reload", 1'b1, 1'b0, 2'd0, 5'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
